// File: rtl/apb_cfg_sequencer_if.sv
// Bundles the command, response and APB signals of the config sequencer.
// The master modport is the sequencer side; slave is the environment side.
interface apb_cfg_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int GAP_W  = 8,
    parameter int POLL_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [DATA_W-1:0] cmd_expect;
    logic [POLL_W-1:0] poll_limit;
    logic [GAP_W-1:0]  poll_gap;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_expect, poll_limit, poll_gap,
        input  rsp_ready, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_expect, poll_limit, poll_gap,
        output rsp_ready, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/apb_cfg_sequencer.sv
// APB master that drains a FIFO of write/read/poll commands in order,
// one transfer outstanding, returning one response per command.
module apb_cfg_sequencer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int GAP_W  = 8,
    parameter int POLL_W = 16
) (
    input logic                 clk,
    input logic                 resetn,
    apb_cfg_sequencer_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_POLL  = 2'b10;

    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp_val;
    } cmd_t;

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, GAP, RESP} state_t;

    state_t            state, state_d;
    cmd_t              mem [DEPTH];
    cmd_t              cur;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              run_q, push, pop, fifo_empty;
    logic [POLL_W-1:0] lim, cnt, cnt_nxt;
    logic [GAP_W-1:0]  gap, gap_cnt;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q, is_write, is_poll, match, exhausted, psel;

    // cmd_ready comes from the registered count only, so a pop never frees a slot in the same cycle
    assign fifo_empty    = (count == '0);
    assign bus.cmd_ready = run_q && (count != CW'(DEPTH));
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{op: bus.cmd_op, addr: bus.cmd_addr,
                                   data: bus.cmd_data, exp_val: bus.cmd_expect};
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            run_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign is_write  = (cur.op == OP_WRITE);
    assign is_poll   = (cur.op == OP_POLL);
    assign cnt_nxt   = cnt + POLL_W'(1);
    assign match     = ((bus.PRDATA ^ cur.exp_val) & cur.data) == '0;
    assign exhausted = (lim != '0) && (cnt_nxt == lim);

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (!fifo_empty) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (bus.PREADY) begin
                         if (is_poll && !match && !exhausted)
                             state_d = (gap == '0) ? SETUP : GAP;
                         else
                             state_d = RESP;
                     end
            GAP:     if (gap_cnt <= GAP_W'(1)) state_d = SETUP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Poll parameters are latched with the command so the source may change them mid-poll
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur        <= '0;
            lim        <= '0;
            gap        <= '0;
            cnt        <= '0;
            gap_cnt    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            if (pop) begin
                cur <= mem[rd_ptr];
                lim <= bus.poll_limit;
                gap <= bus.poll_gap;
                cnt <= '0;
            end
            if (state == ACCESS && bus.PREADY) begin
                cnt        <= cnt_nxt;
                gap_cnt    <= gap;
                rsp_data_q <= is_write ? '0 : bus.PRDATA;
                rsp_err_q  <= is_poll && !match && exhausted;
            end
            if (state == GAP) gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    assign psel        = (state == SETUP) || (state == ACCESS);
    assign bus.PSEL    = psel;
    assign bus.PENABLE = (state == ACCESS);
    assign bus.PWRITE  = psel && is_write;
    assign bus.PADDR   = psel ? cur.addr : '0;
    assign bus.PWDATA  = (psel && is_write) ? cur.data : '0;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = !fifo_empty || (state != IDLE);
endmodule

// File: tb/tb_apb_cfg_sequencer.sv
// Directed bench for apb_cfg_sequencer: a small APB slave model with
// programmable wait states and a poll-hit read index, one task per scenario.
module tb_apb_cfg_sequencer;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    apb_cfg_sequencer_if #(.ADDR_W(8), .DATA_W(32), .GAP_W(8), .POLL_W(16)) bus();

    apb_cfg_sequencer #(.ADDR_W(8), .DATA_W(32), .DEPTH(8), .GAP_W(8), .POLL_W(16)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    int checks = 0, errors = 0;
    int wait_n = 0, acc_wait = 0, reads = 0, poll_hit = 0, en_cycles = 0, cyc = 0;
    logic [31:0] prdata_val = '0;
    logic [7:0]  log_addr[$];
    logic        log_wr[$];
    logic [31:0] log_wdata[$];
    int          log_cyc[$];

    // Slave model: decides PREADY/PRDATA for the coming edge and logs completing transfers
    always @(negedge clk) begin
        cyc++;
        if (bus.PENABLE === 1'b1) en_cycles++;
        if (bus.PSEL === 1'b1 && bus.PENABLE === 1'b1) begin
            if (acc_wait < wait_n) begin
                bus.PREADY = 1'b0;
                acc_wait++;
            end else begin
                bus.PREADY = 1'b1;
                acc_wait = 0;
                if (!bus.PWRITE) begin
                    reads++;
                    bus.PRDATA = (poll_hit != 0 && reads >= poll_hit) ? 32'h8000_0000 : prdata_val;
                end
                log_addr.push_back(bus.PADDR);
                log_wr.push_back(bus.PWRITE);
                log_wdata.push_back(bus.PWDATA);
                log_cyc.push_back(cyc);
            end
        end else begin
            bus.PREADY = 1'b0;
            bus.PRDATA = 32'h0;
            acc_wait = 0;
        end
    end

    task automatic push(input logic [1:0] op, input logic [7:0] addr,
                        input logic [31:0] data, input logic [31:0] expv);
        bit ok = 0;
        bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_data = data; bus.cmd_expect = expv;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (bus.cmd_ready) ok = 1;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL push_timeout addr %h not accepted", addr); end
    endtask

    task automatic wait_rsp(input string name);
        bit ok = 0;
        for (int i = 0; i < 400 && !ok; i++) begin
            if (bus.rsp_valid) ok = 1;
            else @(negedge clk);
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL %s rsp_timeout got rsp_valid 0 exp 1", name); end
    endtask

    task automatic ack();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.PSEL !== 1'b0)    begin errors++; $display("FAIL rst_psel got %b exp 0", bus.PSEL); end
        checks++; if (bus.PENABLE !== 1'b0) begin errors++; $display("FAIL rst_penable got %b exp 0", bus.PENABLE); end
        checks++; if (bus.PWRITE !== 1'b0)  begin errors++; $display("FAIL rst_pwrite got %b exp 0", bus.PWRITE); end
        checks++; if (bus.PADDR !== 8'h0)   begin errors++; $display("FAIL rst_paddr got %h exp 0", bus.PADDR); end
        checks++; if (bus.PWDATA !== 32'h0) begin errors++; $display("FAIL rst_pwdata got %h exp 0", bus.PWDATA); end
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %b exp 0", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL rst_rsp_data got %h exp 0", bus.rsp_data); end
        checks++; if (bus.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err got %b exp 0", bus.rsp_err); end
        checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
        resetn = 1'b1;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready got %b exp 1", bus.cmd_ready); end
    endtask

    task automatic test_write();
        push(2'b00, 8'h00, 32'h0000_000F, 32'h0);
        checks++; if (bus.PSEL !== 1'b0) begin errors++; $display("FAIL wr_early_psel got %b exp 0", bus.PSEL); end
        @(negedge clk);
        checks++; if ({bus.PSEL, bus.PENABLE, bus.PWRITE} !== 3'b101)
            begin errors++; $display("FAIL wr_setup sel/en/wr got %b exp 101", {bus.PSEL, bus.PENABLE, bus.PWRITE}); end
        checks++; if (bus.PWDATA !== 32'hF || bus.PADDR !== 8'h00)
            begin errors++; $display("FAIL wr_setup_data got %h@%h exp f@00", bus.PWDATA, bus.PADDR); end
        @(negedge clk);
        checks++; if ({bus.PSEL, bus.PENABLE} !== 2'b11 || bus.PWDATA !== 32'hF)
            begin errors++; $display("FAIL wr_access got %b/%h exp 11/f", {bus.PSEL, bus.PENABLE}, bus.PWDATA); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL wr_latency rsp_valid got %b exp 1", bus.rsp_valid); end
        checks++; if (bus.PSEL !== 1'b0 || bus.PENABLE !== 1'b0)
            begin errors++; $display("FAIL wr_bus_drop got %b%b exp 00", bus.PSEL, bus.PENABLE); end
        checks++; if (bus.rsp_data !== 32'h0 || bus.rsp_err !== 1'b0)
            begin errors++; $display("FAIL wr_rsp got %h/%b exp 0/0", bus.rsp_data, bus.rsp_err); end
        ack();
        checks++; if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL wr_after_ack got %b/%b exp 0/0", bus.rsp_valid, bus.busy); end
    endtask

    task automatic test_read_wait();
        bit bad = 0;
        wait_n = 3; prdata_val = 32'h0000_000F; en_cycles = 0;
        push(2'b01, 8'h00, 32'hDEAD_BEEF, 32'h0);
        for (int i = 0; i < 50 && !bus.rsp_valid; i++) begin
            if (bus.PSEL && (bus.PADDR !== 8'h00 || bus.PWDATA !== 32'h0 || bus.PWRITE)) bad = 1;
            @(negedge clk);
        end
        wait_rsp("rd");
        checks++; if (en_cycles != 4) begin errors++; $display("FAIL rd_penable_cycles got %0d exp 4", en_cycles); end
        checks++; if (bad) begin errors++; $display("FAIL rd_addr_stable got unstable exp stable"); end
        checks++; if (bus.rsp_data !== 32'h0000_000F || bus.rsp_err !== 1'b0)
            begin errors++; $display("FAIL rd_rsp got %h/%b exp 0000000f/0", bus.rsp_data, bus.rsp_err); end
        ack();
        wait_n = 0;
    endtask

    task automatic test_poll_gap();
        int start = log_cyc.size();
        bit bad = 0;
        reads = 0; poll_hit = 4; prdata_val = 32'h0;
        bus.poll_gap = 8'd2; bus.poll_limit = 16'd0;
        push(2'b10, 8'h10, 32'h8000_0000, 32'h8000_0000);
        wait_rsp("poll");
        checks++; if (reads != 4) begin errors++; $display("FAIL poll_reads got %0d exp 4", reads); end
        checks++; if (bus.rsp_err !== 1'b0 || bus.rsp_data !== 32'h8000_0000)
            begin errors++; $display("FAIL poll_rsp got %h/%b exp 80000000/0", bus.rsp_data, bus.rsp_err); end
        if (log_cyc.size() < start + 4) bad = 1;
        else for (int k = 1; k < 4; k++) if (log_cyc[start+k] - log_cyc[start+k-1] != 4) bad = 1;
        checks++; if (bad) begin errors++; $display("FAIL poll_gap_spacing got irregular exp 4 cycles per read"); end
        ack();
        poll_hit = 0;
    endtask

    task automatic test_poll_limit();
        int start = log_cyc.size();
        reads = 0; poll_hit = 0; prdata_val = 32'h0000_1234;
        bus.poll_gap = 8'd0; bus.poll_limit = 16'd3;
        push(2'b10, 8'h14, 32'h8000_0000, 32'h8000_0000);
        wait_rsp("lim");
        checks++; if (reads != 3) begin errors++; $display("FAIL lim_reads got %0d exp 3", reads); end
        checks++; if (bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'h0000_1234)
            begin errors++; $display("FAIL lim_rsp got %h/%b exp 00001234/1", bus.rsp_data, bus.rsp_err); end
        checks++; if (log_cyc.size() != start + 3 || log_cyc[start+1] - log_cyc[start] != 2)
            begin errors++; $display("FAIL lim_zero_gap got %0d transfers exp 3 back-to-back", log_cyc.size() - start); end
        ack();
        repeat (5) @(negedge clk);
        checks++; if (reads != 3) begin errors++; $display("FAIL lim_no_extra got %0d exp 3", reads); end
        bus.poll_limit = 16'd0;
    endtask

    task automatic test_fifo_full();
        int start = log_addr.size();
        int bad = 0;
        bit refused = 1, acc = 0;
        prdata_val = 32'h0;
        push(2'b00, 8'h30, 32'h0000_00A5, 32'h0);
        wait_rsp("fifo_hold");
        for (int i = 0; i < 8; i++) push(2'b00, 8'h40 + 8'(i), 32'h100 + 32'(i), 32'h0);
        checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready got %b exp 0", bus.cmd_ready); end
        bus.cmd_op = 2'b00; bus.cmd_addr = 8'h48; bus.cmd_data = 32'h108; bus.cmd_valid = 1'b1;
        repeat (3) begin
            if (bus.cmd_ready !== 1'b0) refused = 0;
            @(negedge clk);
        end
        checks++; if (!refused || log_addr.size() != start + 1)
            begin errors++; $display("FAIL fifo_refuse_9th got ready/xfers %b/%0d exp 0/1", !refused, log_addr.size() - start); end
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 100 && !acc; i++) begin
            if (bus.cmd_ready) acc = 1;
            @(negedge clk);
        end
        bus.cmd_valid = 1'b0;
        checks++; if (!acc) begin errors++; $display("FAIL fifo_9th_accept got 0 exp 1"); end
        for (int i = 0; i < 400 && bus.busy; i++) @(negedge clk);
        bus.rsp_ready = 1'b0;
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fifo_drain_busy got %b exp 0", bus.busy); end
        checks++; if (log_addr.size() != start + 10)
            begin errors++; $display("FAIL fifo_drain_count got %0d exp 10", log_addr.size() - start); end
        else begin
            for (int i = 0; i < 10; i++) begin
                logic [7:0]  ea = (i == 0) ? 8'h30 : 8'h40 + 8'(i - 1);
                logic [31:0] ed = (i == 0) ? 32'hA5 : 32'h100 + 32'(i - 1);
                if (log_addr[start+i] !== ea || log_wdata[start+i] !== ed || log_wr[start+i] !== 1'b1) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL fifo_order got %0d out-of-order exp 0", bad); end
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit seen = 0, bad = 0;
        wait_n = 100;
        push(2'b01, 8'h55, 32'h0, 32'h0);
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus.PENABLE) seen = 1;
            else @(negedge clk);
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_access_timeout got 0 exp 1"); end
        resetn = 1'b0;
        @(negedge clk);
        checks++; if ({bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.busy} !== 4'b0000)
            begin errors++; $display("FAIL mid_rst_outputs got %b exp 0000", {bus.PSEL, bus.PENABLE, bus.rsp_valid, bus.busy}); end
        resetn = 1'b1; wait_n = 0; n = log_addr.size();
        repeat (5) begin
            if (bus.rsp_valid !== 1'b0 || bus.PSEL !== 1'b0 || bus.busy !== 1'b0) bad = 1;
            @(negedge clk);
        end
        checks++; if (bad || log_addr.size() != n)
            begin errors++; $display("FAIL mid_no_response got activity exp idle"); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_cmd_ready got %b exp 1", bus.cmd_ready); end
        push(2'b00, 8'h66, 32'h77, 32'h0);
        wait_rsp("mid_after");
        ack();
        checks++; if (log_addr.size() != n + 1 || log_addr[log_addr.size()-1] !== 8'h66)
            begin errors++; $display("FAIL mid_fifo_flushed got %0d xfers exp 1 to 66", log_addr.size() - n); end
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_addr = '0; bus.cmd_data = '0;
        bus.cmd_expect = '0; bus.poll_limit = '0; bus.poll_gap = '0; bus.rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_read_wait();
        test_poll_gap();
        test_poll_limit();
        test_fifo_full();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
